uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
UART transmitter; the outbound counterpart of the debounced receive path. Takes parallel bytes on a valid/ready handshake and serialises them as start, data (LSB first), optional parity and stop bits onto a single line. Bit timing derives from the same single-cycle `samp_clk` enable used by the receive side, at OVERSAMPLE enables per bit. Sits between a byte source (FIFO, register block) and the TX pin.

Parameters:
- DATA_BITS, 8, data bits per frame; legal 5..9.
- OVERSAMPLE, 16, `samp_clk` enables per bit period; legal 2..256.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame; legal 1 or 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- samp_clk  in  1  single-cycle clock enable, OVERSAMPLE per bit period.
- in_data  in  DATA_BITS  byte to send; sampled only on accept.
- in_valid  in  1  source has a byte.
- in_ready  out  1  block can accept a byte.
- out  out  1  serial TX line; idle high.
- busy  out  1  frame in progress.

Behaviour:
- Reset (rst_n low, async):
  - out = 1, busy = 0, in_ready = 0, state IDLE, counters 0.
  - in_ready rises on the first clk edge after rst_n deasserts.
- Reset mid-frame: frame abandoned; out returns to 1 immediately (async, not at a clock edge); no partial completion after release.
- Accept: on a clk edge where in_valid && in_ready.
  - Accept does not depend on samp_clk.
  - in_data is latched into the shift register; later changes to in_data are ignored.
  - Same edge: in_ready <= 0, busy <= 1, out <= 0 (start bit begins), state START.
- States: IDLE -> START -> DATA -> [PARITY if PARITY != 0] -> STOP -> IDLE.
- Bit timing: every non-IDLE state bit lasts exactly OVERSAMPLE samp_clk pulses.
  - A samp_clk high in the accept cycle is not counted.
  - Tick counter is $clog2(OVERSAMPLE) bits wide and wraps to 0 at OVERSAMPLE-1, on the tick that ends the bit.
  - On that same edge, out takes the next bit value.
- START: out = 0.
- DATA: out = shift register bit 0; shift right at each bit boundary. Bit counter counts 0..DATA_BITS-1.
- PARITY:
  - even: out = XOR of data bits.
  - odd: out = inverted XOR of data bits.
  - Parity is computed from the latched byte.
- STOP:
  - out = 1 for STOP_BITS*OVERSAMPLE ticks.
  - On the final tick: state IDLE, busy <= 0, in_ready <= 1 (same edge).
- Back-to-back: a new accept is possible the cycle after in_ready rises. The idle-high gap between frames is exactly the stop bit(s) plus at most one samp_clk period.
- in_valid while busy: ignored, no effect, no queueing.
- samp_clk absent: state and out hold indefinitely, with no glitches on out.
- All outputs registered; out never changes except at a bit boundary, accept, or reset.

Decomposition:
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - parity constants PARITY_NONE = 0, PARITY_ODD = 1, PARITY_EVEN = 2.
  - Also used by the receive side.
- One sub-module is natural: `uart_bit_timer`.
  - samp_clk tick counter with a clear input and a `bit_done` pulse.
  - Reusable for a future receive-side framer.
- Shifter and FSM stay in the top module.

Test Plan:
- Default params, samp_clk every 4 clk, send 0x55:
  - out sequence per 64-clk bit: 0,1,0,1,0,1,0,1,0,1;
  - busy high 640 clk;
  - in_ready high again on the clk after the final stop tick.
- PARITY = 2, send 0x07 -> parity bit 1. PARITY = 1, send 0x07 -> parity bit 0. Frame is 11 bits in both cases.
- in_valid held high with 0xA5 then 0x3C:
  - two contiguous frames, stop gap exactly 16 ticks (+ ≤ 1 samp_clk);
  - 0x3C appears only after first in_ready rise;
  - in_data changed mid-frame does not corrupt 0xA5.
- Assert rst_n low during data bit 4 of 0xFF:
  - out = 1 within the same cycle (async), busy = 0;
  - in_ready 0 until the first clk after release;
  - next frame 0x81 transmits correctly.
- STOP_BITS = 2, DATA_BITS = 7, send 0x7F: 7 data bits then 32 high ticks before in_ready rises.
- samp_clk withheld for 100 clk mid-bit 3: out constant throughout; bit 3 lengthens by exactly the gap; remaining bits unaffected.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, parity modes and a parity helper.
// Used by both the transmit serializer and the receive side.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   // Parity over the low nbits of data; even mode is the plain XOR, odd its inverse.
   function automatic logic parity_of(input logic [8:0] data, input int nbits, input int mode);
      logic p;
      p = 1'b0;
      for (int i = 0; i < 9; i++) begin
         p = p ^ (data[i] & (i < nbits));
      end
      return (mode == PARITY_ODD) ? ~p : p;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Counts samp_clk enables within one bit period and flags the enable that ends it.
// Holding clear_i keeps the count at zero and suppresses bit_done_o.
module uart_bit_timer #(
   parameter int OVERSAMPLE = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic tick_i,
   output logic bit_done_o
);

   localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next tick count: wraps on the enable that closes the bit.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (tick_i) begin
         if (cnt_q == LAST_TICK) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CW'(1'b1);
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Tick count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bit_done_o = tick_i & ~clear_i & (cnt_q == LAST_TICK);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: accepts a word on valid/ready and sends start, data (LSB first),
// optional parity and stop bits, each lasting OVERSAMPLE samp_clk enables.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 samp_clk,
   input  logic [DATA_BITS-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 out,
   output logic                 busy
);

   localparam int BW = $clog2(DATA_BITS);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

   uart_state_e          state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
   logic                 stop_cnt_q, stop_cnt_d;
   logic                 par_q, par_d;
   logic                 out_q, out_d;
   logic                 busy_q, busy_d;
   logic                 ready_q, ready_d;
   logic                 bit_done_s;

   // The timer is held cleared while idle, so an enable in the accept cycle is not counted.
   uart_bit_timer #(
      .OVERSAMPLE(OVERSAMPLE)
   ) u_bit_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (state_q == ST_IDLE),
      .tick_i    (samp_clk),
      .bit_done_o(bit_done_s)
   );

   // Frame sequencing; out_d always carries the value of the bit that starts on this edge.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      par_d      = par_q;
      out_d      = out_q;
      busy_d     = busy_q;
      ready_d    = ready_q;
      case (state_q)
         ST_IDLE: begin
            ready_d = 1'b1;
            if (in_valid && ready_q) begin
               state_d    = ST_START;
               shift_d    = in_data;
               par_d      = parity_of(9'(in_data), DATA_BITS, PARITY);
               bit_cnt_d  = '0;
               stop_cnt_d = 1'b0;
               out_d      = 1'b0;
               busy_d     = 1'b1;
               ready_d    = 1'b0;
            end else begin
               out_d  = 1'b1;
               busy_d = 1'b0;
            end
         end
         ST_START: begin
            if (bit_done_s) begin
               state_d   = ST_DATA;
               out_d     = shift_q[0];
               shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
               bit_cnt_d = '0;
            end else begin
               state_d = ST_START;
            end
         end
         ST_DATA: begin
            if (bit_done_s && (bit_cnt_q == LAST_BIT)) begin
               if (PARITY != PARITY_NONE) begin
                  state_d = ST_PARITY;
                  out_d   = par_q;
               end else begin
                  state_d    = ST_STOP;
                  out_d      = 1'b1;
                  stop_cnt_d = 1'b0;
               end
            end else if (bit_done_s) begin
               out_d     = shift_q[0];
               shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + BW'(1'b1);
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_PARITY: begin
            if (bit_done_s) begin
               state_d    = ST_STOP;
               out_d      = 1'b1;
               stop_cnt_d = 1'b0;
            end else begin
               state_d = ST_PARITY;
            end
         end
         ST_STOP: begin
            if (bit_done_s && (stop_cnt_q == STOP_LAST)) begin
               state_d = ST_IDLE;
               out_d   = 1'b1;
               busy_d  = 1'b0;
               ready_d = 1'b1;
            end else if (bit_done_s) begin
               stop_cnt_d = stop_cnt_q + 1'b1;
            end else begin
               state_d = ST_STOP;
            end
         end
         default: begin
            state_d = ST_IDLE;
            out_d   = 1'b1;
            busy_d  = 1'b0;
            ready_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset forces the line high without waiting for a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         par_q      <= 1'b0;
         out_q      <= 1'b1;
         busy_q     <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         par_q      <= par_d;
         out_q      <= out_d;
         busy_q     <= busy_d;
         ready_q    <= ready_d;
      end
   end

   assign in_ready = ready_q;
   assign out      = out_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four parameter variants share clock, reset and samp_clk;
// every frame is checked clock-by-clock against a bit list built from the frame rules.
module tb_uart_tx_serializer;

   localparam int OS = 16;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       samp_clk = 1'b0;
   logic [7:0] din      = 8'h00;
   logic       valid [4];
   logic       out_w [4];
   logic       busy_w [4];
   logic       rdy_w [4];

   int ds_a [4] = '{8, 8, 8, 7};
   int par_a [4] = '{0, 2, 1, 0};
   int sb_a [4] = '{1, 1, 1, 2};

   int n_chk     = 0;
   int n_fail    = 0;
   bit samp_en   = 1'b1;
   int samp_mode = 0;
   int samp_per  = 4;
   int samp_div  = 0;

   uart_tx_serializer #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(1)) u_plain (
      .clk(clk), .rst_n(rst_n), .samp_clk(samp_clk), .in_data(din), .in_valid(valid[0]),
      .in_ready(rdy_w[0]), .out(out_w[0]), .busy(busy_w[0]));
   uart_tx_serializer #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(2), .STOP_BITS(1)) u_even (
      .clk(clk), .rst_n(rst_n), .samp_clk(samp_clk), .in_data(din), .in_valid(valid[1]),
      .in_ready(rdy_w[1]), .out(out_w[1]), .busy(busy_w[1]));
   uart_tx_serializer #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(1), .STOP_BITS(1)) u_odd (
      .clk(clk), .rst_n(rst_n), .samp_clk(samp_clk), .in_data(din), .in_valid(valid[2]),
      .in_ready(rdy_w[2]), .out(out_w[2]), .busy(busy_w[2]));
   uart_tx_serializer #(.DATA_BITS(7), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(2)) u_stop2 (
      .clk(clk), .rst_n(rst_n), .samp_clk(samp_clk), .in_data(din[6:0]), .in_valid(valid[3]),
      .in_ready(rdy_w[3]), .out(out_w[3]), .busy(busy_w[3]));

   always #5 clk = ~clk;

   // samp_clk: fixed period (mode 0) or random non-adjacent pulses (mode 1), gated by samp_en.
   initial begin
      forever begin
         @(negedge clk);
         if (samp_mode == 0) begin
            samp_clk = samp_en && (samp_div == samp_per - 1);
            samp_div = (samp_div >= samp_per - 1) ? 0 : samp_div + 1;
         end else begin
            samp_clk = samp_en && !samp_clk && ($urandom_range(0, 2) == 0);
         end
      end
   end

   task automatic send(input int id, input logic [7:0] d, input bit keep, output bit ok);
      ok = 1'b0;
      @(negedge clk);
      din = d;
      valid[id] = 1'b1;
      for (int i = 0; i < 3000 && !ok; i++) begin
         if (rdy_w[id] === 1'b1) ok = 1'b1;
         else @(negedge clk);
      end
      if (ok) begin
         @(posedge clk);
         #1;
      end
      if (!keep || !ok) valid[id] = 1'b0;
   endtask

   // Returns with the next posedge being a samp_clk edge (fixed-period mode only).
   task automatic align_to_tick();
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         if (samp_clk) break;
      end
      repeat (3) @(negedge clk);
   endtask

   // Follows one frame from just after its accept edge; every clock the line must show
   // bits[ticks_seen / OS]. Optionally stops early or withholds samp_clk for 100 clocks.
   task automatic watch_frame(input int id, input logic [7:0] d, input int stop_tick,
                              input int hold_tick, input bit mut, output int bad_bits,
                              output int clks, output bit tmo, output bit hold_steady);
      logic bits [$];
      logic bad [$];
      logic p, hold_val;
      int   nt, limit, k, hold_left;
      bit   held, tick;
      p = 1'b0;
      bits.push_back(1'b0);
      for (int i = 0; i < ds_a[id]; i++) begin
         bits.push_back(d[i]);
         p = p ^ d[i];
      end
      if (par_a[id] == 2) bits.push_back(p);
      else if (par_a[id] == 1) bits.push_back(~p);
      for (int s = 0; s < sb_a[id]; s++) bits.push_back(1'b1);
      foreach (bits[i]) bad.push_back(1'b0);
      nt = bits.size() * OS;
      limit = (stop_tick > 0) ? stop_tick : nt;
      k = 0; clks = 0; tmo = 1'b0; held = 1'b0; hold_left = 0;
      hold_steady = 1'b1; hold_val = 1'b1;
      while (k < limit && !tmo) begin
         @(posedge clk);
         tick = samp_clk;
         #1;
         clks++;
         if (tick) k++;
         if (mut) din = 8'($urandom);
         if (k < nt && (out_w[id] !== bits[k / OS] || busy_w[id] !== 1'b1 || rdy_w[id] !== 1'b0))
            bad[k / OS] = 1'b1;
         if (hold_left > 0) begin
            if (out_w[id] !== hold_val) hold_steady = 1'b0;
            hold_left--;
            if (hold_left == 0) samp_en = 1'b1;
         end else if (hold_tick > 0 && k == hold_tick && !held) begin
            held = 1'b1; hold_left = 100; hold_val = out_w[id]; samp_en = 1'b0;
         end
         if (clks > 4000) tmo = 1'b1;
      end
      samp_en = 1'b1;
      bad_bits = 0;
      foreach (bad[i]) if (bad[i]) bad_bits++;
   endtask

   task automatic test_reset();
      #12;
      for (int id = 0; id < 4; id++) begin
         n_chk++;
         if (out_w[id] !== 1'b1 || busy_w[id] !== 1'b0 || rdy_w[id] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state id=%0d: out=%b busy=%b ready=%b, required 1 0 0",
                     id, out_w[id], busy_w[id], rdy_w[id]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_chk++;
      if (rdy_w[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready_early: ready=%b, required 0", rdy_w[0]);
      end
      @(posedge clk);
      #1;
      for (int id = 0; id < 4; id++) begin
         n_chk++;
         if (rdy_w[id] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_rise id=%0d: ready=%b, required 1", id, rdy_w[id]);
         end
      end
   endtask

   task automatic test_basic();
      bit ok, tmo, hs;
      int bad, clks;
      samp_mode = 0;
      align_to_tick();
      send(0, 8'h55, 1'b0, ok);
      n_chk++;
      if (!ok || out_w[0] !== 1'b0 || busy_w[0] !== 1'b1 || rdy_w[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_accept: ok=%0d out=%b busy=%b ready=%b, required 1 0 1 0",
                  ok, out_w[0], busy_w[0], rdy_w[0]);
      end
      watch_frame(0, 8'h55, 0, 0, 1'b1, bad, clks, tmo, hs);
      n_chk++;
      if (tmo || bad != 0) begin
         n_fail++;
         $display("FAIL basic_bits: %0d bad bit periods (timeout=%0d), required 0", bad, tmo);
      end
      n_chk++;
      if (clks != 640) begin
         n_fail++;
         $display("FAIL basic_busy_len: busy lasted %0d clk, required 640", clks);
      end
      n_chk++;
      if (out_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || rdy_w[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_end: out=%b busy=%b ready=%b, required 1 0 1",
                  out_w[0], busy_w[0], rdy_w[0]);
      end
   endtask

   task automatic test_parity();
      bit ok, tmo, hs;
      int bad, clks;
      for (int id = 1; id <= 2; id++) begin
         send(id, 8'h07, 1'b0, ok);
         watch_frame(id, 8'h07, 0, 0, 1'b0, bad, clks, tmo, hs);
         n_chk++;
         if (!ok || tmo || bad != 0) begin
            n_fail++;
            $display("FAIL parity_frame id=%0d: ok=%0d bad_bits=%0d timeout=%0d, required 1 0 0",
                     id, ok, bad, tmo);
         end
         n_chk++;
         if (busy_w[id] !== 1'b0 || rdy_w[id] !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_end id=%0d: busy=%b ready=%b after 11 bits, required 0 1",
                     id, busy_w[id], rdy_w[id]);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok, tmo, hs;
      int bad, clks;
      send(0, 8'hA5, 1'b1, ok);
      din = 8'h3C;
      watch_frame(0, 8'hA5, 0, 0, 1'b0, bad, clks, tmo, hs);
      n_chk++;
      if (!ok || tmo || bad != 0 || rdy_w[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_first: ok=%0d bad_bits=%0d ready=%b, required 1 0 1", ok, bad, rdy_w[0]);
      end
      @(posedge clk);
      #1;
      valid[0] = 1'b0;
      n_chk++;
      if (out_w[0] !== 1'b0 || busy_w[0] !== 1'b1 || rdy_w[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_second_accept: out=%b busy=%b ready=%b, required 0 1 0",
                  out_w[0], busy_w[0], rdy_w[0]);
      end
      watch_frame(0, 8'h3C, 0, 0, 1'b0, bad, clks, tmo, hs);
      n_chk++;
      if (tmo || bad != 0 || rdy_w[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_second: bad_bits=%0d ready=%b, required 0 1", bad, rdy_w[0]);
      end
   endtask

   task automatic test_reset_mid();
      bit ok, tmo, hs, stayed;
      int bad, clks;
      send(0, 8'hFF, 1'b0, ok);
      watch_frame(0, 8'hFF, 5 * OS + 5, 0, 1'b0, bad, clks, tmo, hs);
      #1;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (!ok || bad != 0 || out_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || rdy_w[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_async: ok=%0d bad=%0d out=%b busy=%b ready=%b, required 1 0 1 0 0",
                  ok, bad, out_w[0], busy_w[0], rdy_w[0]);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_chk++;
      if (rdy_w[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_ready_early: ready=%b, required 0", rdy_w[0]);
      end
      @(posedge clk);
      #1;
      n_chk++;
      if (rdy_w[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_ready_rise: ready=%b, required 1", rdy_w[0]);
      end
      stayed = 1'b1;
      repeat (80) begin
         @(posedge clk);
         #1;
         if (out_w[0] !== 1'b1 || busy_w[0] !== 1'b0) stayed = 1'b0;
      end
      n_chk++;
      if (!stayed) begin
         n_fail++;
         $display("FAIL rstmid_no_resume: line left idle after reset, required idle high");
      end
      send(0, 8'h81, 1'b0, ok);
      watch_frame(0, 8'h81, 0, 0, 1'b0, bad, clks, tmo, hs);
      n_chk++;
      if (!ok || tmo || bad != 0 || rdy_w[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_next_frame: ok=%0d bad_bits=%0d ready=%b, required 1 0 1",
                  ok, bad, rdy_w[0]);
      end
   endtask

   task automatic test_stop2();
      bit ok, tmo, hs;
      int bad, clks;
      send(3, 8'h7F, 1'b0, ok);
      watch_frame(3, 8'h7F, 0, 0, 1'b0, bad, clks, tmo, hs);
      n_chk++;
      if (!ok || tmo || bad != 0 || rdy_w[3] !== 1'b1 || busy_w[3] !== 1'b0) begin
         n_fail++;
         $display("FAIL stop2_frame: ok=%0d bad_bits=%0d ready=%b busy=%b, required 1 0 1 0",
                  ok, bad, rdy_w[3], busy_w[3]);
      end
   endtask

   task automatic test_samp_hold();
      bit ok, tmo, hs;
      int bad, clks;
      samp_mode = 0;
      align_to_tick();
      send(0, 8'h5A, 1'b0, ok);
      watch_frame(0, 8'h5A, 0, 4 * OS + 7, 1'b0, bad, clks, tmo, hs);
      n_chk++;
      if (!ok || tmo || bad != 0 || !hs) begin
         n_fail++;
         $display("FAIL hold_frame: ok=%0d bad_bits=%0d steady=%0d, required 1 0 1", ok, bad, hs);
      end
      n_chk++;
      if (clks != 740) begin
         n_fail++;
         $display("FAIL hold_length: frame took %0d clk, required 740", clks);
      end
   endtask

   task automatic test_random();
      bit ok, tmo, hs;
      int bad, clks, id;
      logic [7:0] d;
      samp_mode = 1;
      for (int n = 0; n < 12; n++) begin
         id = $urandom_range(0, 3);
         d = 8'($urandom);
         send(id, d, 1'b0, ok);
         watch_frame(id, d, 0, 0, 1'b1, bad, clks, tmo, hs);
         n_chk++;
         if (!ok || tmo || bad != 0 || rdy_w[id] !== 1'b1 || out_w[id] !== 1'b1) begin
            n_fail++;
            $display("FAIL random_frame id=%0d data=%h: ok=%0d bad_bits=%0d ready=%b, required 1 0 1",
                     id, d, ok, bad, rdy_w[id]);
         end
      end
      samp_mode = 0;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) valid[i] = 1'b0;
      test_reset();
      test_basic();
      test_parity();
      test_back_to_back();
      test_reset_mid();
      test_stop2();
      test_samp_hold();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
